alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
//  Multi-cycle unsigned multiplier controller for MULTU/HiLo. It time-shares one external
//  32-bit ALU in ADD mode for a shift-add algorithm: WIDTH iterations, one per clock.
//  Sits beside the EX stage. The pipeline raises start, stalls while busy, then reads product.
// PARAMETERS
//  WIDTH   32   operand width in bits; product is 2*WIDTH bits
//  CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk          in   1         single clock; all state updates on the rising edge
//  reset        in   1         synchronous, active-high
//  start        in   1         request a multiply; sampled only in IDLE
//  dataA        in   WIDTH     multiplicand; captured on an accepted start
//  dataB        in   WIDTH     multiplier; captured on an accepted start
//  alu_a        out  WIDTH     ALU operand A = hi register
//  alu_b        out  WIDTH     ALU operand B = lo[0] ? mcand : 0
//  alu_signal   out  3         ALU op; constant ADD (3'b010)
//  alu_result   in   WIDTH     combinational ALU sum, same cycle
//  alu_carry    in   1         combinational ALU carry-out, same cycle
//  busy         out  1         high in RUN
//  done         out  1         one-cycle pulse in DONE
//  product      out  2*WIDTH   {hi,lo}; valid from DONE until the next accepted start
// BEHAVIOUR
//  - Reset (sync): state=IDLE; hi, lo, mcand, cnt = 0; busy=0; done=0; product=0.
//  - Reset wins over every other input on the same edge.
//  - States: IDLE, RUN, DONE (state encoding defined in the shared package).
//  - IDLE: on an edge with start=1:
//      mcand<=dataA; lo<=dataB; hi<=0; cnt<=0; state<=RUN.
//    With start=0, IDLE holds all registers, so product keeps the last result.
//  - RUN: each edge performs one iteration:
//      {hi,lo} <= {alu_carry, alu_result, lo[WIDTH-1:1]}; cnt<=cnt+1.
//    When cnt==WIDTH-1 on that edge: state<=DONE.
//  - DONE: done=1 for exactly one cycle; next edge -> IDLE, and done returns to 0.
//  - Latency: start accepted at edge k; iterations at edges k+1..k+WIDTH; done high
//    during the cycle following edge k+WIDTH.
//    A new start is accepted no earlier than the edge after DONE, i.e. edge k+WIDTH+2.
//  - Outputs: busy = (state==RUN); done = (state==DONE). Both are decoded from
//    registered state with no combinational path from start.
//  - alu_signal is driven ADD in every state; alu_a/alu_b are driven in every state
//    but only consumed in RUN.
//  - Width rule: the hi+mcand sum is WIDTH+1 bits. alu_carry is the MSB shifted into hi;
//    no overflow is possible.
//  - start high in RUN or DONE: ignored and not queued. A start held high through DONE
//    is accepted at the first IDLE edge.
//  - dataA/dataB changing while busy: no effect, since operands were captured at start.
//  - Reset mid-RUN: operation aborted, product=0, no done pulse.
//  - Operand 0 on either side: still runs the full WIDTH iterations (fixed latency,
//    no early exit).
// STRUCTURE
//  - Shared package alu_pkg:
//      ALU signal codes AND=3'b000, OR=3'b001, ADD=3'b010, SUB=3'b110, SLT=3'b111;
//      sequencer state encoding IDLE/RUN/DONE.
//  - All other ALU controllers in the codebase import these codes from alu_pkg.
//  - No sub-module: FSM, counter and hi/lo/mcand registers live in this module.
//  - The ALU is instantiated by the parent and connected through the alu_* ports.
// TESTING
//  1. dataA=3, dataB=5, start 1 cycle -> busy for 32 cycles; done at edge+33;
//     product=64'h0000_0000_0000_000F.
//  2. dataA=dataB=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001; exercises
//     alu_carry=1 into hi.
//  3. dataA=32'h1234_5678, dataB=0 -> latency still 33 edges; product=0;
//     alu_b=0 in every RUN cycle.
//  4. start=1 again at RUN cycle 10 with new operands -> ignored; result matches the
//     first operands; exactly one done pulse.
//  5. reset=1 at RUN cycle 17 -> next cycle state IDLE, busy=0, product=0,
//     and no done for the aborted operation.
//  6. Back-to-back: start held high continuously with 7 x 9 ->
//     done every 34 cycles; product=63 each time.
//  - Scoreboard: 64-bit reference multiply; alu_signal==3'b010 asserted every cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions.
//   alu_op_e    - ALU signal codes consumed by the external 32-bit ALU.
//   seq_state_e - state encoding of the multiply sequencer.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

endpackage : alu_pkg

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle unsigned shift-add multiplier controller.
// Borrows an external ALU in ADD mode for WIDTH iterations, one per clock.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start             multiply request, sampled only in IDLE
//   dataA, dataB      multiplicand / multiplier, captured on accepted start
//   alu_a, alu_b      ALU operands (hi, lo[0] ? mcand : 0)
//   alu_signal        ALU op, constant ADD
//   alu_result/carry  combinational ALU sum and carry-out
//   busy              high while iterating
//   done              one-cycle completion pulse
//   product           {hi,lo}; valid from done until the next accepted start
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_signal,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          mcand_d = dataA;
          lo_d    = dataB;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        // The WIDTH+1 bit partial sum shifts right by one; the multiplier
        // bits consumed from lo make room for the low product bits.
        {hi_d, lo_d} = {alu_carry, alu_result, lo_q[WIDTH-1:1]};
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = SEQ_DONE;
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_a      = hi_q;
  assign alu_b      = lo_q[0] ? mcand_q : '0;
  assign alu_signal = ALU_ADD;
  assign busy       = (state_q == SEQ_RUN);
  assign done       = (state_q == SEQ_DONE);
  assign product    = {hi_q, lo_q};

endmodule : alu_mul_sequencer

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: scoreboard bench. A cycle-level acceptance model pushes
// the expected product and completion cycle for each accepted start; a monitor
// on the falling edge compares done/busy/product/alu outputs against it.
module tb_alu_mul_sequencer;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [W-1:0]   dataA, dataB;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [2:0]     alu_signal;
  logic           alu_carry;
  logic           busy, done;
  logic [2*W-1:0] product;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dataA      (dataA),
    .dataB      (dataB),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_signal (alu_signal),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  // External ALU in ADD mode
  assign {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

  typedef struct {
    logic [63:0] prod;
    int unsigned dcyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc       = 0;
  int unsigned next_free = 0;
  int unsigned bfrom     = 1;
  int unsigned bto       = 0;
  logic [W-1:0] cur_b    = '0;
  logic [63:0] last_prod = '0;
  bit          stable    = 1'b0;
  int unsigned vectors   = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Acceptance model: an op takes WIDTH+2 edges from accept to next possible accept.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      sb.delete();
      next_free = cyc + 1;
      bfrom     = 1;
      bto       = 0;
      last_prod = '0;
      stable    = 1'b1;
    end else if (start && cyc >= next_free) begin
      sb.push_back('{prod: {32'b0, dataA} * {32'b0, dataB}, dcyc: cyc + W});
      bfrom     = cyc;
      bto       = cyc + W - 1;
      next_free = cyc + W + 2;
      cur_b     = dataB;
      stable    = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit exp_done, exp_busy;
    exp_done = (sb.size() > 0) && (sb[0].dcyc == cyc);
    exp_busy = (cyc >= bfrom) && (cyc <= bto);
    chk("alu_signal", 64'(alu_signal), 64'(3'b010));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("done", 64'(done), 64'(exp_done));
    if (exp_busy && cur_b == '0) chk("alu_b_zero", 64'(alu_b), 64'd0);
    if (exp_done) begin
      chk("product", product, sb[0].prod);
      last_prod = sb[0].prod;
      stable    = 1'b1;
      void'(sb.pop_front());
    end else if (stable) begin
      chk("product_hold", product, last_prod);
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    dataA = a; dataB = b; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dataA = '0; dataB = '0;
    step(2);
    reset = 1'b0;
    step(2);

    op(32'd3, 32'd5);                   step(40);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF);   step(40);
    op(32'h1234_5678, 32'd0);           step(40);

    // start re-asserted mid-run with different operands must be ignored
    op(32'd1000, 32'd77);  step(9);
    op(32'hDEAD_BEEF, 32'h0BAD_F00D);   step(35);

    // reset during run aborts the operation
    op(32'hCAFE_0001, 32'h0000_1234);   step(16);
    reset = 1'b1; step(1); reset = 1'b0; step(10);

    // start held high: one result every WIDTH+2 cycles
    dataA = 32'd7; dataB = 32'd9; start = 1'b1;
    step(3 * (W + 2) + 1);
    start = 1'b0; step(40);

    // randomized traffic, including starts while busy and rare resets
    for (int i = 0; i < 1500; i++) begin
      int unsigned sel;
      sel   = $urandom_range(0, 9);
      dataA = (sel == 0) ? '0 : (sel == 1) ? '1 : W'($urandom);
      sel   = $urandom_range(0, 9);
      dataB = (sel == 0) ? '0 : (sel == 1) ? '1 : W'($urandom);
      start = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step(1);
    end
    start = 1'b0; reset = 1'b0;
    step(W + 4);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_alu_mul_sequencer
